// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: packs stream words into AES key/blocks, sequences the AES core and streams results out
module aes_stream_ctrl #(
    parameter int DATA_W = 32,
    parameter int BLK_S  = 128,
    parameter int KEY_S  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              aes_en,
    output logic              aes_cipher_mode,
    output logic              aes_decipher_mode,
    output logic              aes_key_exp_mode,
    output logic [KEY_S-1:0]  aes_key,
    output logic [BLK_S-1:0]  aes_in_blk,
    input  logic [BLK_S-1:0]  aes_out_blk,
    input  logic              aes_en_o,
    output logic              busy,
    output logic              pkt_err
);
    typedef enum logic [2:0] {IDLE, RECV_KEY, RECV_BLK, START, WAIT, SEND, DRAIN} state_t;
    state_t state, state_nx;
    logic [1:0] cnt, mode, code;
    logic [BLK_S-1:0] res;
    logic last_blk, drain, err_nx, in_hs, out_hs, fourth, recv, op;

    assign code   = s_axis_tdata[1:0];
    assign in_hs  = s_axis_tvalid & s_axis_tready;
    assign out_hs = m_axis_tvalid & m_axis_tready;
    assign fourth = cnt == 2'd3;
    assign recv   = state == RECV_KEY || state == RECV_BLK;
    assign op     = state == START || state == WAIT;
    assign err_nx = in_hs && ((state == IDLE && (s_axis_tlast || code == 2'd0)) ||
                              (recv && s_axis_tlast && !fourth) ||
                              (state == RECV_KEY && fourth && !s_axis_tlast));

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (in_hs && !s_axis_tlast) state_nx = code == 2'd0 ? DRAIN : code == 2'd3 ? RECV_KEY : RECV_BLK;
            RECV_KEY,
            RECV_BLK: if (in_hs && (s_axis_tlast || fourth)) state_nx = fourth ? START : IDLE;
            START:    state_nx = WAIT;
            WAIT:     if (aes_en_o) state_nx = mode != 2'd3 ? SEND : drain ? DRAIN : IDLE;
            SEND:     if (out_hs && fourth) state_nx = last_blk ? IDLE : RECV_BLK;
            DRAIN:    if (in_hs && s_axis_tlast) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // outputs decoded from state; tready is held low while reset is asserted so every output reads 0
    always_comb begin
        s_axis_tready     = !reset && (state == IDLE || recv || state == DRAIN);
        m_axis_tvalid     = state == SEND;
        m_axis_tlast      = m_axis_tvalid && fourth && last_blk;
        m_axis_tdata      = m_axis_tvalid ? res[BLK_S-1 -: DATA_W] : '0;
        aes_en            = state == START;
        aes_cipher_mode   = op && mode == 2'd1;
        aes_decipher_mode = op && mode == 2'd2;
        aes_key_exp_mode  = op && mode == 2'd3;
        busy              = state != IDLE;
    end

    // datapath: words shift in MSB-first, results shift out MSB-first, mode survives across data blocks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aes_key    <= '0;
            aes_in_blk <= '0;
            res        <= '0;
            cnt        <= '0;
            mode       <= '0;
            last_blk   <= 1'b0;
            drain      <= 1'b0;
            pkt_err    <= 1'b0;
        end else begin
            pkt_err <= err_nx;
            if (in_hs && state == IDLE) begin
                mode  <= code;
                drain <= 1'b0;
            end
            if (in_hs && state == RECV_KEY) aes_key <= {aes_key[KEY_S-DATA_W-1:0], s_axis_tdata};
            if (in_hs && state == RECV_KEY && fourth) drain <= !s_axis_tlast;
            if (in_hs && state == RECV_BLK) begin
                aes_in_blk <= {aes_in_blk[BLK_S-DATA_W-1:0], s_axis_tdata};
                last_blk   <= s_axis_tlast;
            end
            if ((in_hs && recv) || out_hs) cnt <= (in_hs && recv && s_axis_tlast) ? 2'd0 : cnt + 2'd1;
            if (state == WAIT && aes_en_o && mode == 2'd3) mode <= 2'd0;
            if (state == WAIT && aes_en_o && mode != 2'd3) res <= aes_out_blk;
            if (out_hs) res <= {res[BLK_S-DATA_W-1:0], {DATA_W{1'b0}}};
        end
    end
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: randomized packet bench with a behavioural AES stand-in and packet-level reference model
module tb_aes_stream_ctrl;
    logic clk = 0, reset = 1;
    logic [31:0] s_axis_tdata = 0, m_axis_tdata;
    logic s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tready;
    logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1;
    logic aes_en, aes_cipher_mode, aes_decipher_mode, aes_key_exp_mode, aes_en_o = 0, busy, pkt_err;
    logic [127:0] aes_key, aes_in_blk, aes_out_blk = 0;

    aes_stream_ctrl dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .aes_en(aes_en), .aes_cipher_mode(aes_cipher_mode), .aes_decipher_mode(aes_decipher_mode),
        .aes_key_exp_mode(aes_key_exp_mode), .aes_key(aes_key), .aes_in_blk(aes_in_blk),
        .aes_out_blk(aes_out_blk), .aes_en_o(aes_en_o), .busy(busy), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    int vec = 0, miss = 0;
    logic [31:0] pkt[$], exp_q[$], got_q[$];
    logic exp_last[$], got_last[$];
    logic [127:0] model_key = 0;
    int exp_en, exp_err, en_cnt, err_cnt;
    int stall_viol = 0, mode_viol = 0, lat_viol = 0, en_lat_viol = 0;
    int rdy_mode = 0, core_lat = 0, core_cnt = 0;
    bit gap_en = 0, to_flag = 0, in_op = 0, pv = 0, pr = 0, pl = 0, pdata = 0;
    logic [31:0] pd;
    logic [1:0] cur_code;
    logic [127:0] core_res;

    // stand-in AES: encrypt mixes with a constant, other modes swap halves; both keyed
    function automatic logic [127:0] core_fn(input logic [1:0] m, input logic [127:0] k, input logic [127:0] b);
        return m == 2'd1 ? (b ^ k ^ 128'h5a5a_0ff0_c33c_a5a5_1234_8765_dead_beef) : ({b[63:0], b[127:64]} ^ k);
    endfunction

    // output sink, protocol monitors and the behavioural core, all on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            core_cnt = 0; aes_en_o = 0; in_op = 0; pv = 0; pdata = 0;
        end else begin
            m_axis_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~m_axis_tready : 1'($urandom_range(0, 1));
            if (m_axis_tvalid && m_axis_tready) begin got_q.push_back(m_axis_tdata); got_last.push_back(m_axis_tlast); end
            if (pv && !pr && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl)) stall_viol++;
            pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata; pl = m_axis_tlast;
            if (aes_en_o && pdata && !m_axis_tvalid) lat_viol++;
            pdata = aes_cipher_mode | aes_decipher_mode;
            if (aes_en_o) in_op = 0;
            if (aes_en) in_op = 1;
            if ({aes_key_exp_mode, aes_decipher_mode, aes_cipher_mode} !== (in_op ? 3'(1 << (cur_code - 2'd1)) : 3'd0)) mode_viol++;
            if (aes_en) en_cnt++;
            if (pkt_err) err_cnt++;
            aes_en_o = 0;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin aes_en_o = 1; aes_out_blk = core_res; end
            end
            if (aes_en) begin
                core_cnt = core_lat != 0 ? core_lat : int'($urandom_range(1, 6));
                core_res = core_fn({aes_decipher_mode | aes_key_exp_mode, aes_cipher_mode | aes_key_exp_mode}, aes_key, aes_in_blk);
            end
        end
    end

    // packet-level reference: expected outputs, start pulses and error pulses for pkt
    task automatic model_pkt();
        int n = pkt.size(), nb;
        logic [31:0] w0 = pkt[0];
        logic [127:0] r;
        exp_q.delete(); exp_last.delete(); exp_en = 0; exp_err = 0;
        if (n == 1 || w0[1:0] == 2'd0) begin exp_err = 1; return; end
        if (w0[1:0] == 2'd3) begin
            if (n < 5) begin exp_err = 1; return; end
            model_key = {pkt[1], pkt[2], pkt[3], pkt[4]};
            exp_en = 1; exp_err = n > 5 ? 1 : 0;
            return;
        end
        nb = (n - 1) / 4;
        exp_err = (n - 1) % 4 != 0 ? 1 : 0;
        for (int b = 0; b < nb; b++) begin
            r = core_fn(w0[1:0], model_key, {pkt[4*b+1], pkt[4*b+2], pkt[4*b+3], pkt[4*b+4]});
            exp_en++;
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back(32'(r >> (32 * (3 - j))));
                exp_last.push_back(b == nb - 1 && exp_err == 0 && j == 3);
            end
        end
    endtask

    task automatic drive();
        logic [31:0] w0 = pkt[0];
        int t;
        @(negedge clk);
        for (int i = 0; i < pkt.size(); i++) begin
            while (gap_en && $urandom_range(0, 3) == 0) @(negedge clk);
            s_axis_tdata = pkt[i]; s_axis_tvalid = 1; s_axis_tlast = (i == pkt.size() - 1);
            t = 0;
            while (!s_axis_tready && t < 3000) begin @(negedge clk); t++; end
            if (t >= 3000) begin to_flag = 1; s_axis_tvalid = 0; break; end
            @(posedge clk);
            @(negedge clk);
            s_axis_tvalid = 0; s_axis_tlast = 0;
            if (((w0[1:0] == 2'd3 && i == 4) || ((w0[1:0] == 2'd1 || w0[1:0] == 2'd2) && i > 0 && i % 4 == 0)) && !aes_en)
                en_lat_viol++;
        end
    endtask

    task automatic run_pkt();
        int t = 0;
        logic [31:0] w0 = pkt[0];
        model_pkt();
        cur_code = w0[1:0];
        got_q.delete(); got_last.delete(); en_cnt = 0; err_cnt = 0; to_flag = 0;
        drive();
        while ((busy || got_q.size() < exp_q.size()) && t < 3000) begin @(negedge clk); t++; end
        if (t >= 3000) to_flag = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        vec++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, aes_en, aes_cipher_mode, aes_decipher_mode,
             aes_key_exp_mode, aes_key, aes_in_blk, busy, pkt_err} !== '0) begin
            miss++; $display("FAIL reset_outputs: tready=%b tvalid=%b busy=%b key=%h blk=%h, required all 0",
                             s_axis_tready, m_axis_tvalid, busy, aes_key, aes_in_blk);
        end
        @(negedge clk); reset = 0; #1;
        vec++;
        if (s_axis_tready !== 1'b1 || busy !== 1'b0) begin
            miss++; $display("FAIL idle_after_reset: tready=%b busy=%b, required 1/0", s_axis_tready, busy);
        end
    endtask

    task automatic test_key();
        pkt = '{32'h3, 32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
        run_pkt();
        vec++; if (aes_key !== 128'h000102030405060708090a0b0c0d0e0f) begin miss++; $display("FAIL key_value: %h, required 000102030405060708090a0b0c0d0e0f", aes_key); end
        vec++; if (en_cnt !== 1 || got_q.size() !== 0) begin miss++; $display("FAIL key_op: en=%0d words=%0d, required 1/0", en_cnt, got_q.size()); end
        vec++; if (busy !== 1'b0 || to_flag || err_cnt !== 0) begin miss++; $display("FAIL key_done: busy=%b timeout=%b err=%0d, required 0/0/0", busy, to_flag, err_cnt); end
        vec++; if (mode_viol !== 0 || en_lat_viol !== 0) begin miss++; $display("FAIL key_mode: mode_viol=%0d en_lat_viol=%0d, required 0/0", mode_viol, en_lat_viol); end
    endtask

    task automatic test_cipher();
        logic [31:0] ct[$];
        for (int p = 0; p < 2; p++) begin
            pkt = p == 0 ? '{32'h1, 32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff} : '{32'h2, ct[0], ct[1], ct[2], ct[3]};
            run_pkt();
            ct = got_q;
            vec++; if (got_q.size() !== 4 || to_flag) begin miss++; $display("FAIL cipher%0d_count: %0d words timeout=%b, required 4/0", p, got_q.size(), to_flag); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                vec++;
                if ({got_last[i], got_q[i]} !== {exp_last[i], exp_q[i]}) begin
                    miss++; $display("FAIL cipher%0d_word%0d: %b/%h, required %b/%h", p, i, got_last[i], got_q[i], exp_last[i], exp_q[i]);
                end
            end
            vec++; if (en_cnt !== 1 || err_cnt !== 0) begin miss++; $display("FAIL cipher%0d_pulses: en=%0d err=%0d, required 1/0", p, en_cnt, err_cnt); end
        end
        vec++; if (mode_viol !== 0 || lat_viol !== 0 || en_lat_viol !== 0) begin
            miss++; $display("FAIL cipher_timing: mode_viol=%0d lat_viol=%0d en_lat_viol=%0d, required 0", mode_viol, lat_viol, en_lat_viol);
        end
    endtask

    task automatic test_back_to_back();
        rdy_mode = 1;
        pkt = '{32'h1};
        repeat (12) pkt.push_back($urandom);
        run_pkt();
        vec++; if (got_q.size() !== 12 || en_cnt !== 3 || to_flag) begin
            miss++; $display("FAIL b2b_count: words=%0d en=%0d timeout=%b, required 12/3/0", got_q.size(), en_cnt, to_flag);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vec++;
            if ({got_last[i], got_q[i]} !== {exp_last[i], exp_q[i]}) begin
                miss++; $display("FAIL b2b_word%0d: %b/%h, required %b/%h", i, got_last[i], got_q[i], exp_last[i], exp_q[i]);
            end
        end
        vec++; if (stall_viol !== 0 || err_cnt !== 0) begin miss++; $display("FAIL b2b_stall: stall_viol=%0d err=%0d, required 0/0", stall_viol, err_cnt); end
        rdy_mode = 0;
    endtask

    task automatic test_errors();
        int errs = 0, ens = 0, words = 0;
        pkt = '{32'h1, 32'hdeadbeef, 32'hcafef00d};
        run_pkt(); errs += err_cnt; ens += en_cnt; words += got_q.size();
        pkt = '{32'hfffffff0, 32'h11111111, 32'h22222222};
        run_pkt(); errs += err_cnt; ens += en_cnt; words += got_q.size();
        vec++; if (errs !== 2 || ens !== 0 || words !== 0) begin
            miss++; $display("FAIL err_pair: err=%0d en=%0d words=%0d, required 2/0/0", errs, ens, words);
        end
        vec++; if (busy !== 1'b0 || to_flag) begin miss++; $display("FAIL err_idle: busy=%b timeout=%b, required 0/0", busy, to_flag); end
        pkt = '{32'h2};
        run_pkt();
        vec++; if (err_cnt !== 1 || en_cnt !== 0 || busy !== 1'b0) begin miss++; $display("FAIL err_cmd_last: err=%0d en=%0d busy=%b, required 1/0/0", err_cnt, en_cnt, busy); end
        pkt = '{32'h7, 32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100, 32'h99999999, 32'h88888888};
        run_pkt();
        vec++; if (err_cnt !== 1 || en_cnt !== 1 || busy !== 1'b0 || to_flag) begin
            miss++; $display("FAIL key_extra: err=%0d en=%0d busy=%b timeout=%b, required 1/1/0/0", err_cnt, en_cnt, busy, to_flag);
        end
        vec++; if (aes_key !== model_key) begin miss++; $display("FAIL key_extra_value: %h, required %h", aes_key, model_key); end
    endtask

    task automatic test_reset_wait();
        core_lat = 40;
        pkt = '{32'h1, $urandom, $urandom, $urandom, $urandom};
        model_pkt(); cur_code = 2'd1; to_flag = 0;
        drive();
        repeat (3) @(negedge clk);
        vec++; if (busy !== 1'b1 || aes_cipher_mode !== 1'b1 || to_flag) begin
            miss++; $display("FAIL wait_reached: busy=%b cipher=%b timeout=%b, required 1/1/0", busy, aes_cipher_mode, to_flag);
        end
        #2 reset = 1;
        #1;
        vec++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, aes_en, aes_cipher_mode, aes_decipher_mode,
             aes_key_exp_mode, aes_key, aes_in_blk, busy, pkt_err} !== '0) begin
            miss++; $display("FAIL async_reset: tready=%b busy=%b cipher=%b key=%h blk=%h, required all 0",
                             s_axis_tready, busy, aes_cipher_mode, aes_key, aes_in_blk);
        end
        repeat (2) @(negedge clk);
        reset = 0; model_key = 0; core_lat = 0;
        pkt = '{32'h3, $urandom, $urandom, $urandom, $urandom};
        run_pkt();
        pkt = '{32'h1, $urandom, $urandom, $urandom, $urandom};
        run_pkt();
        vec++; if (got_q.size() !== 4 || en_cnt !== 1 || to_flag) begin
            miss++; $display("FAIL post_reset_count: words=%0d en=%0d timeout=%b, required 4/1/0", got_q.size(), en_cnt, to_flag);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vec++;
            if ({got_last[i], got_q[i]} !== {exp_last[i], exp_q[i]}) begin
                miss++; $display("FAIL post_reset_word%0d: %b/%h, required %b/%h", i, got_last[i], got_q[i], exp_last[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] c;
        for (int k = 0; k < 24; k++) begin
            rdy_mode = $urandom_range(0, 2); gap_en = 1'($urandom_range(0, 1));
            core_lat = $urandom_range(0, 4);
            c = 2'($urandom_range(0, 3));
            pkt = '{{$urandom_range(0, 255), 22'h0, c}};
            repeat (c == 2'd3 ? 4 + $urandom_range(0, 2) : c == 2'd0 ? $urandom_range(0, 2) : $urandom_range(0, 12)) pkt.push_back($urandom);
            run_pkt();
            vec++; if (got_q.size() !== exp_q.size() || en_cnt !== exp_en || err_cnt !== exp_err || to_flag) begin
                miss++; $display("FAIL rand%0d_counts: words=%0d en=%0d err=%0d to=%b, required %0d/%0d/%0d/0",
                                 k, got_q.size(), en_cnt, err_cnt, to_flag, exp_q.size(), exp_en, exp_err);
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                vec++;
                if ({got_last[i], got_q[i]} !== {exp_last[i], exp_q[i]}) begin
                    miss++; $display("FAIL rand%0d_word%0d: %b/%h, required %b/%h", k, i, got_last[i], got_q[i], exp_last[i], exp_q[i]);
                end
            end
        end
        vec++; if (stall_viol !== 0 || mode_viol !== 0 || lat_viol !== 0 || en_lat_viol !== 0) begin
            miss++; $display("FAIL rand_protocol: stall=%0d mode=%0d lat=%0d en_lat=%0d, required 0", stall_viol, mode_viol, lat_viol, en_lat_viol);
        end
    endtask

    initial begin
        test_reset();
        test_key();
        test_cipher();
        test_back_to_back();
        test_errors();
        test_reset_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
